// File: rtl/rtu_gap_timer_ram_pkg.sv
// Gap-threshold constant functions shared by the RTU timing block.
// RTU_FIXED_GAP_EN: above 19200 baud use fixed 750 us / 1750 us gaps instead of character-based ones.
package rtu_timing_pkg;

    localparam int CHAR_BITS = 11;

    // 64-bit intermediates: CLK_FREQ*77 overflows 32 bits at common clock rates
    function automatic int t15_cycles(input int clk_hz, input int baud);
        longint c;
        longint b;
        c = longint'(clk_hz);
        b = longint'(baud);
`ifdef RTU_FIXED_GAP_EN
        if (baud > 19200) return int'(c * 750 / 1000000);
`endif
        return int'(c * 3 * CHAR_BITS / (2 * b));
    endfunction

    function automatic int t35_cycles(input int clk_hz, input int baud);
        longint c;
        longint b;
        c = longint'(clk_hz);
        b = longint'(baud);
`ifdef RTU_FIXED_GAP_EN
        if (baud > 19200) return int'(c * 1750 / 1000000);
`endif
        return int'(c * 7 * CHAR_BITS / (2 * b));
    endfunction

    function automatic int gap_cnt_width(input int clk_hz, input int baud);
        int m;
        m = t35_cycles(clk_hz, baud);
        if (t15_cycles(clk_hz, baud) > m) m = t15_cycles(clk_hz, baud);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rtu_gap_timer_ram_if.sv
// Receive-timing and staging-RAM signal bundle; master is the surrounding logic, slave is the block.
interface rtu_gap_timer_ram_if #(
    parameter int A_WIDTH = 4,
    parameter int D_WIDTH = 16
);
    logic               rx_done;
    logic               rx_state;
    logic               rx_drop_frame;
    logic               rx_new_frame;
    logic               ena;
    logic               enb;
    logic               wea;
    logic               web;
    logic [A_WIDTH-1:0] addra;
    logic [A_WIDTH-1:0] addrb;
    logic [D_WIDTH-1:0] dia;
    logic [D_WIDTH-1:0] dib;
    logic [D_WIDTH-1:0] doa;
    logic [D_WIDTH-1:0] dob;

    modport master (
        output rx_done, rx_state, ena, enb, wea, web, addra, addrb, dia, dib,
        input  rx_drop_frame, rx_new_frame, doa, dob
    );

    modport slave (
        input  rx_done, rx_state, ena, enb, wea, web, addra, addrb, dia, dib,
        output rx_drop_frame, rx_new_frame, doa, dob
    );
endinterface

// File: rtl/rtu_gap_timer_ram_gap_timer.sv
// Idle-gap timer: one-cycle pulse THRESH cycles after the last rx_done/rx_state, then disarms.
// Latency THRESH cycles from the sampling edge; no backpressure.
module rtu_gap_timer #(
    parameter int THRESH = 7161,
    parameter int CNT_W  = $clog2(THRESH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_done,
    input  logic rx_state,
    output logic gap_pulse
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(THRESH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_pulse;

    // Clear has priority over terminal count, so a character ending exactly at the threshold suppresses the pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else if (rx_done || rx_state) begin
            r_cnt   <= '0;
            r_armed <= 1'b1;
            r_pulse <= 1'b0;
        end else if (r_armed) begin
            if (r_cnt == TERM) begin
                r_armed <= 1'b0;
                r_pulse <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_pulse <= 1'b0;
            end
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign gap_pulse = r_pulse;

endmodule

// File: rtl/rtu_gap_timer_ram.sv
// Modbus RTU 1.5T/3.5T idle-gap pulses plus a read-first dual-port staging RAM (1-cycle reads, A wins write collisions).
// RTU_FIXED_GAP_EN selects fixed 750/1750 us gaps above 19200 baud; no backpressure anywhere.
module rtu_gap_timer_ram
    import rtu_timing_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int A_WIDTH   = 4,
    parameter int D_WIDTH   = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    rtu_gap_timer_ram_if.slave   bus
);

    localparam int T15   = t15_cycles(CLK_FREQ, BAUD_RATE);
    localparam int T35   = t35_cycles(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = gap_cnt_width(CLK_FREQ, BAUD_RATE);

    logic w_drop;
    logic w_new;

    rtu_gap_timer #(.THRESH(T15), .CNT_W(CNT_W)) u_gap15 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_done   (bus.rx_done),
        .rx_state  (bus.rx_state),
        .gap_pulse (w_drop)
    );

    rtu_gap_timer #(.THRESH(T35), .CNT_W(CNT_W)) u_gap35 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_done   (bus.rx_done),
        .rx_state  (bus.rx_state),
        .gap_pulse (w_new)
    );

    assign bus.rx_drop_frame = w_drop;
    assign bus.rx_new_frame  = w_new;

    logic [D_WIDTH-1:0] r_mem [2**A_WIDTH];
    logic [D_WIDTH-1:0] r_doa;
    logic [D_WIDTH-1:0] r_dob;

    // Port A write is issued last so it takes the location when both ports write one address
    always_ff @(posedge clk) begin
        if (bus.enb && bus.web) r_mem[bus.addrb] <= bus.dib;
        if (bus.ena && bus.wea) r_mem[bus.addra] <= bus.dia;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_doa <= '0;
            r_dob <= '0;
        end else begin
            if (bus.ena) r_doa <= r_mem[bus.addra];
            if (bus.enb) r_dob <= r_mem[bus.addrb];
        end
    end

    assign bus.doa = r_doa;
    assign bus.dob = r_dob;

endmodule

// File: tb/tb_rtu_gap_timer_ram.sv
// Directed bench for rtu_gap_timer_ram: gap pulse timing, cancellation, reset mid-count and RAM port behaviour.
module tb_rtu_gap_timer_ram;

`ifdef RTU_FIXED_GAP_EN
    localparam int T15    = 37500;
    localparam int T35    = 87500;
    localparam int MID    = 60000;
    localparam int RST_AT = 20000;
`else
    localparam int T15    = 7161;
    localparam int T35    = 16710;
    localparam int MID    = 10000;
    localparam int RST_AT = 2000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtu_gap_timer_ram_if #(.A_WIDTH(4), .D_WIDTH(16)) bus ();

    rtu_gap_timer_ram #(
        .CLK_FREQ  (50000000),
        .BAUD_RATE (115200),
        .A_WIDTH   (4),
        .D_WIDTH   (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    int n_drop = 0;
    int n_new = 0;
    int drop_at = 0;
    int new_at = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_drop_frame === 1'b1) begin
            n_drop  = n_drop + 1;
            drop_at = cyc;
        end
        if (bus.rx_new_frame === 1'b1) begin
            n_new  = n_new + 1;
            new_at = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // k is the index of the clock edge that samples rx_done
    task automatic pulse_done(output int k);
        k = cyc + 1;
        bus.rx_done = 1'b1;
        tick(1);
        bus.rx_done = 1'b0;
    endtask

    task automatic clr_counts();
        n_drop = 0;
        n_new  = 0;
    endtask

    int k;

    initial begin
        bus.rx_done  = 1'b0;
        bus.rx_state = 1'b0;
        bus.ena = 1'b0; bus.enb = 1'b0; bus.wea = 1'b0; bus.web = 1'b0;
        bus.addra = '0; bus.addrb = '0; bus.dia = '0; bus.dib = '0;

        tick(3);
        chk("rst_drop", bus.rx_drop_frame, 0);
        chk("rst_new",  bus.rx_new_frame, 0);
        chk("rst_doa",  bus.doa, 0);
        chk("rst_dob",  bus.dob, 0);
        rst_n = 1'b1;
        tick(2);

        // RAM: write A, read B next cycle
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 4'd3; bus.dia = 16'hA5A5;
        tick(1);
        bus.ena = 1'b0; bus.wea = 1'b0; bus.enb = 1'b1; bus.addrb = 4'd3;
        tick(1);
        chk("ram_b_read", bus.dob, 16'hA5A5);
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 4'd3; bus.dia = 16'h1234;
        tick(1);
        chk("ram_b_old", bus.dob, 16'hA5A5);
        chk("ram_a_rdfirst", bus.doa, 16'hA5A5);
        bus.ena = 1'b0; bus.wea = 1'b0;
        tick(1);
        chk("ram_b_new", bus.dob, 16'h1234);
        // both ports write address 5: A wins
        bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 4'd5; bus.dia = 16'h1111;
        bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = 4'd5; bus.dib = 16'h2222;
        tick(1);
        bus.wea = 1'b0; bus.web = 1'b0;
        tick(1);
        chk("ram_coll_a", bus.doa, 16'h1111);
        chk("ram_coll_b", bus.dob, 16'h1111);
        bus.ena = 1'b0; bus.enb = 1'b0; bus.addra = 4'd3; bus.addrb = 4'd3;
        tick(2);
        chk("ram_hold_a", bus.doa, 16'h1111);
        chk("ram_hold_b", bus.dob, 16'h1111);
        bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = 4'd7; bus.dib = 16'hBEEF;
        tick(1);
        bus.enb = 1'b0; bus.web = 1'b0; bus.ena = 1'b1; bus.addra = 4'd7;
        tick(1);
        chk("ram_b_to_a", bus.doa, 16'hBEEF);
        bus.ena = 1'b0;

        // idle after reset: no gap pulses
        clr_counts();
        tick(20000);
        chk("idle_drop_cnt", n_drop, 0);
        chk("idle_new_cnt",  n_new, 0);

        // single character then silence
        clr_counts();
        pulse_done(k);
        tick(T35 + 1000);
        chk("single_drop_cnt", n_drop, 1);
        chk("single_drop_at",  drop_at - k, T15);
        chk("single_new_cnt",  n_new, 1);
        chk("single_new_at",   new_at - k, T35);

        // rx_state during the gap restarts timing from the later rx_done
        clr_counts();
        pulse_done(k);
        tick(4999);
        bus.rx_state = 1'b1;
        tick(1000);
        chk("cancel_drop_cnt", n_drop, 0);
        chk("cancel_new_cnt",  n_new, 0);
        bus.rx_state = 1'b0;
        pulse_done(k);
        tick(T35 + 20);
        chk("restart_drop_cnt", n_drop, 1);
        chk("restart_drop_at",  drop_at - k, T15);
        chk("restart_new_cnt",  n_new, 1);
        chk("restart_new_at",   new_at - k, T35);

        // gap between 1.5T and 3.5T: drop only
        clr_counts();
        pulse_done(k);
        tick(MID - 1);
        bus.rx_state = 1'b1;
        tick(10);
        bus.rx_state = 1'b0;
        chk("mid_drop_cnt", n_drop, 1);
        chk("mid_drop_at",  drop_at - k, T15);
        chk("mid_new_cnt",  n_new, 0);

        // reset while counting: nothing fires afterwards
        tick(RST_AT);
        rst_n = 1'b0;
        tick(2);
        chk("rstmid_drop", bus.rx_drop_frame, 0);
        chk("rstmid_dob",  bus.dob, 0);
        rst_n = 1'b1;
        clr_counts();
        tick(T35 + 300);
        chk("post_rst_drop_cnt", n_drop, 0);
        chk("post_rst_new_cnt",  n_new, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rtu_gap_timer_ram.md
# rtu_gap_timer_ram

Modbus RTU receive-side timing and buffer block. It measures bus idle time after each received character and produces the 1.5-character "drop frame" pulse and the 3.5-character "new frame" pulse. It also contains a 16-bit dual-port RAM used to stage response words between the function handler (port A) and the transmit CRC/serialiser path (port B). It sits between the UART byte receiver and the frame parser / response generator.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 115200, UART bit rate
- A_WIDTH, 4, RAM address width; depth is 2^A_WIDTH
- D_WIDTH, 16, RAM data width
- Reset is rst_n, asynchronous, active-low; clock is clk.
- clk  in  1  system clock; all logic, including both RAM ports, is on clk
- rst_n  in  1  asynchronous active-low reset
- rx_done  in  1  one-cycle pulse marking the end of a received character
- rx_state  in  1  high while the UART receiver is inside a character
- rx_drop_frame  out  1  one-cycle pulse when idle time reaches 1.5 characters
- rx_new_frame  out  1  one-cycle pulse when idle time reaches 3.5 characters
- ena, enb  in  1  port A/B enable
- wea, web  in  1  port A/B write enable (qualified by the port's enable)
- addra, addrb  in  A_WIDTH  port A/B address
- dia, dib  in  D_WIDTH  port A/B write data
- doa, dob  out  D_WIDTH  port A/B registered read data

## Operation
- Character time is 11 bits.
- Thresholds use integer division:
  - T15 = CLK_FREQ*33/(2*BAUD_RATE)
  - T35 = CLK_FREQ*77/(2*BAUD_RATE)
- Each gap timer has an idle counter and an armed flag:
  - Reset: counter 0, disarmed, output 0.
  - rx_done=1 or rx_state=1: counter cleared to 0, timer armed.
  - Armed and idle: counter increments by 1 per cycle.
  - Counter reaches T-1 while armed: output pulses for exactly one cycle, then the timer disarms and the counter holds.
  - While disarmed, the output stays 0 until the next rx_done or rx_state.
- If rx_state rises before a threshold is reached, the pending pulse is cancelled and the counter restarts from the later rx_done.
- Simultaneous rx_done and terminal count: clear wins and no pulse is emitted.
- A gap between 1.5T and 3.5T yields rx_drop_frame only. A gap of at least 3.5T yields rx_drop_frame, then rx_new_frame T35-T15 cycles later.
- Counter width is $clog2(max threshold)+1 bits. The counter never wraps because it holds at T-1 when disarmed.
- RAM behaviour:
  - Write: on clk when en&we, mem[addr] <= din.
  - Read: on clk when en, dout <= mem[addr] (read-first: returns the old data on a same-address write).
  - Both ports writing the same address in the same cycle: port A wins.
  - Port B reading an address port A writes in the same cycle returns the old data.
  - doa/dob hold their value while the port's enable is low.
  - RAM contents are not reset; doa/dob reset to 0.

## Timing
- All outputs are 0 in reset.
- Gap pulse latency: rx_done sampled at edge k gives a pulse high in the cycle after edge k+T.
- RAM read latency is 1 cycle. Write data is visible on the other port's read at the next edge after the write edge.
- Asserting reset mid-count clears the counters and disarms both timers; no pulse is emitted after release until rx activity.

## Configuration
- RTU_FIXED_GAP_EN defined and BAUD_RATE > 19200: fixed Modbus gaps are used, T15 = CLK_FREQ*750/1000000 and T35 = CLK_FREQ*1750/1000000 (37500 / 87500 at 50 MHz).
- Not defined: the character-based formulas above apply at every baud rate.

## Structure
- Shared package rtu_timing_pkg holds:
  - the constant functions computing T15, T35 and the counter width from CLK_FREQ/BAUD_RATE;
  - the 11-bit character constant.
- One sub-module, rtu_gap_timer (parameter THRESH; ports clk, rst_n, rx_done, rx_state, gap_pulse), instantiated twice, for 1.5T and 3.5T.
- The RAM is inline in the top level.

## Test plan
All cases use the defaults, without the macro (T15=7161, T35=16710).
- Release reset with no rx activity for 20000 cycles -> both outputs stay 0.
- Single rx_done pulse then idle -> rx_drop_frame high exactly 7161 cycles later and rx_new_frame high exactly 16710 cycles later, each for one cycle, and no repeat over a further 40000 cycles.
- rx_done, then rx_state high at +5000 for 1000 cycles, then rx_done -> no pulse before the second rx_done; pulses land 7161/16710 cycles after it.
- rx_done, then rx_state rises at +10000 -> only rx_drop_frame fires; rx_new_frame is suppressed.
- RAM: write 16'hA5A5 to address 3 via port A, read address 3 on port B next cycle -> dob=16'hA5A5 one cycle later. A same-cycle port A write and port B read of address 3 with 16'h1234 -> dob returns 16'hA5A5 (old data).
- With RTU_FIXED_GAP_EN defined -> pulses at 37500 and 87500 cycles after rx_done. Asserting rst_n low at +20000 -> no pulse after release.
